dlsc_pcie_s6_tx_arb: RTL and testbench

DLSC_PCIE_S6_TX_ARB -- requirements
Module: dlsc_pcie_s6_tx_arb

---
 rtl/dlsc_pcie_s6_pkg.sv | 30 +++
 rtl/dlsc_pcie_s6_tx_slice.sv | 48 ++++
 rtl/dlsc_pcie_s6_tx_arb.sv | 160 ++++++++++++++++
 tb/tb_dlsc_pcie_s6_tx_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlsc_pcie_s6_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dlsc_pcie_s6_pkg
//  Brief    : Shared types and constants for the Spartan-6 PCIe TX path.
//  Revision : 1.0 - initial release
// ============================================================================
package dlsc_pcie_s6_pkg;

  // Transmit arbiter states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_OB  = 2'd1,
    ST_GNT_CPL = 2'd2
  } arb_state_t;

  // Encoding of the last_grant flag
  localparam logic c_GRANT_OB  = 1'b0;
  localparam logic c_GRANT_CPL = 1'b1;

  // Idle level of the active-low TRN sideband signals
  localparam logic c_TRN_IDLE_N = 1'b1;

  // Output slice payload: {sof, eof, data[31:0]}
  localparam int c_DATA_W  = 32;
  localparam int c_SLICE_W = c_DATA_W + 2;
  localparam int c_EOF_BIT = c_DATA_W;
  localparam int c_SOF_BIT = c_DATA_W + 1;

endpackage
`default_nettype wire

// File: rtl/dlsc_pcie_s6_tx_slice.sv
`default_nettype none
// ============================================================================
//  Module   : dlsc_pcie_s6_tx_slice
//  Brief    : Single-stage valid/ready register slice carrying data+eof+sof.
//  Revision : 1.0 - initial release
// ============================================================================
module dlsc_pcie_s6_tx_slice
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int WIDTH = c_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Slot can take a new word when empty or when it drains this cycle
  assign o_ready = !r_full || i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;

  // Load/drain the slot; a flush empties and clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (o_ready) begin
      r_full <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlsc_pcie_s6_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : dlsc_pcie_s6_tx_arb
//  Brief    : Packet arbiter between outbound and completion TLP streams
//             feeding the Spartan-6 PCIe TRN transmit interface.
//  Revision : 1.0 - initial release
// ============================================================================
module dlsc_pcie_s6_tx_arb
  import dlsc_pcie_s6_pkg::*;
#(
  parameter bit          CPL_PRIO   = 1'b0,
  parameter int unsigned BUF_AV_MIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  // outbound request stream
  output logic        o_ob_ready,
  input  logic        i_ob_valid,
  input  logic [31:0] i_ob_data,
  input  logic        i_ob_last,
  // completion stream
  output logic        o_cpl_ready,
  input  logic        i_cpl_valid,
  input  logic [31:0] i_cpl_data,
  input  logic        i_cpl_last,
  // TRN transmit
  output logic [31:0] o_trn_td,
  output logic        o_trn_tsof_n,
  output logic        o_trn_teof_n,
  output logic        o_trn_tsrc_rdy_n,
  input  logic        i_trn_tdst_rdy_n,
  output logic        o_trn_tsrc_dsc_n,
  output logic        o_trn_tstr_n,
  input  logic [5:0]  i_trn_tbuf_av,
  input  logic        i_trn_lnk_up_n,
  output logic        o_tx_busy
);

  localparam logic [5:0] c_BUF_AV_MIN = 6'(BUF_AV_MIN);

  arb_state_t r_state, w_state_nxt;
  logic r_last_grant, r_first;
  logic r_ob_mid, r_ob_dropmid, r_cpl_mid, r_cpl_dropmid;
  logic w_link_up, w_can_start, w_pick_cpl;
  logic w_ob_drop, w_cpl_drop, w_ob_req, w_cpl_req;
  logic w_gnt_ob, w_gnt_cpl, w_ob_acc, w_cpl_acc;
  logic w_ob_ready, w_cpl_ready, w_ob_take, w_cpl_take;
  logic w_slice_ready, w_slice_full, w_slice_valid;
  logic [c_SLICE_W-1:0] w_slice_din, w_slice_dout;

  assign w_link_up   = !i_trn_lnk_up_n;
  // A stream is discarded while the link is down, and afterwards until the
  // end of any packet it was partway through
  assign w_ob_drop   = !w_link_up || r_ob_dropmid;
  assign w_cpl_drop  = !w_link_up || r_cpl_dropmid;
  assign w_ob_req    = i_ob_valid && !w_ob_drop;
  assign w_cpl_req   = i_cpl_valid && !w_cpl_drop;
  assign w_can_start = w_link_up && (i_trn_tbuf_av >= c_BUF_AV_MIN);
  assign w_pick_cpl  = w_cpl_req && (!w_ob_req || CPL_PRIO || (r_last_grant == c_GRANT_OB));

  // Grant decode, accept qualification and next-state
  always_comb begin
    w_gnt_ob    = 1'b0;
    w_gnt_cpl   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_can_start) begin
          if (w_pick_cpl)    w_gnt_cpl = 1'b1;
          else if (w_ob_req) w_gnt_ob  = 1'b1;
        end
      end
      ST_GNT_OB:  w_gnt_ob  = w_link_up && !r_ob_dropmid;
      ST_GNT_CPL: w_gnt_cpl = w_link_up && !r_cpl_dropmid;
      default:    w_state_nxt = ST_IDLE;
    endcase
    w_ob_acc  = w_gnt_ob  && i_ob_valid  && w_slice_ready;
    w_cpl_acc = w_gnt_cpl && i_cpl_valid && w_slice_ready;
    if (!w_link_up)     w_state_nxt = ST_IDLE;
    else if (w_ob_acc)  w_state_nxt = i_ob_last  ? ST_IDLE : ST_GNT_OB;
    else if (w_cpl_acc) w_state_nxt = i_cpl_last ? ST_IDLE : ST_GNT_CPL;
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_ob_ready  = w_ob_drop  || (w_gnt_ob  && w_slice_ready);
  assign w_cpl_ready = w_cpl_drop || (w_gnt_cpl && w_slice_ready);
  assign w_ob_take   = i_ob_valid  && w_ob_ready;
  assign w_cpl_take  = i_cpl_valid && w_cpl_ready;

  // Round-robin history and start-of-packet tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= c_GRANT_OB;
      r_first      <= 1'b1;
    end else begin
      if (w_ob_acc && i_ob_last)        r_last_grant <= c_GRANT_OB;
      else if (w_cpl_acc && i_cpl_last) r_last_grant <= c_GRANT_CPL;
      if (!w_link_up)                   r_first <= 1'b1;
      else if (w_ob_acc || w_cpl_acc)   r_first <= w_slice_din[c_EOF_BIT];
    end
  end

  // Per-stream packet position, used to keep discarding to a packet boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ob_mid      <= 1'b0;
      r_ob_dropmid  <= 1'b0;
      r_cpl_mid     <= 1'b0;
      r_cpl_dropmid <= 1'b0;
    end else begin
      if (w_ob_take) begin
        r_ob_mid     <= !i_ob_last;
        r_ob_dropmid <= w_ob_drop && !i_ob_last;
      end else if (!w_link_up) begin
        r_ob_dropmid <= r_ob_mid;
      end
      if (w_cpl_take) begin
        r_cpl_mid     <= !i_cpl_last;
        r_cpl_dropmid <= w_cpl_drop && !i_cpl_last;
      end else if (!w_link_up) begin
        r_cpl_dropmid <= r_cpl_mid;
      end
    end
  end

  assign w_slice_valid = w_ob_acc || w_cpl_acc;
  assign w_slice_din   = w_gnt_cpl ? {r_first, i_cpl_last, i_cpl_data}
                                   : {r_first, i_ob_last,  i_ob_data};

  dlsc_pcie_s6_tx_slice #(
    .WIDTH (c_SLICE_W)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (!w_link_up),
    .i_valid (w_slice_valid),
    .o_ready (w_slice_ready),
    .i_data  (w_slice_din),
    .o_valid (w_slice_full),
    .o_data  (w_slice_dout),
    .i_ready (!i_trn_tdst_rdy_n)
  );

  assign o_ob_ready       = rst_n && w_ob_ready;
  assign o_cpl_ready      = rst_n && w_cpl_ready;
  assign o_trn_td         = w_slice_dout[c_DATA_W-1:0];
  assign o_trn_tsof_n     = !(w_slice_full && w_slice_dout[c_SOF_BIT]);
  assign o_trn_teof_n     = !(w_slice_full && w_slice_dout[c_EOF_BIT]);
  assign o_trn_tsrc_rdy_n = !(w_slice_full && w_link_up);
  assign o_trn_tsrc_dsc_n = c_TRN_IDLE_N;
  assign o_trn_tstr_n     = c_TRN_IDLE_N;
  assign o_tx_busy        = (r_state != ST_IDLE) || w_slice_full;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_pcie_s6_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dlsc_pcie_s6_tx_arb
//  Brief    : Directed self-checking bench for dlsc_pcie_s6_tx_arb.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dlsc_pcie_s6_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ob_valid, ob_last, cpl_valid, cpl_last;
  logic [31:0] ob_data, cpl_data;
  logic        dst_rdy_n, lnk_up_n;
  logic [5:0]  tbuf_av;

  logic        a_ob_ready, a_cpl_ready, a_tsof_n, a_teof_n, a_tsrc_n, a_dsc_n, a_tstr_n, a_busy;
  logic [31:0] a_td;
  logic        p_ob_ready, p_cpl_ready, p_tsof_n, p_teof_n, p_tsrc_n, p_dsc_n, p_tstr_n, p_busy;
  logic [31:0] p_td;

  always #5 clk = ~clk;

  dlsc_pcie_s6_tx_arb #(.CPL_PRIO(1'b0), .BUF_AV_MIN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_ob_ready(a_ob_ready), .i_ob_valid(ob_valid), .i_ob_data(ob_data), .i_ob_last(ob_last),
    .o_cpl_ready(a_cpl_ready), .i_cpl_valid(cpl_valid), .i_cpl_data(cpl_data), .i_cpl_last(cpl_last),
    .o_trn_td(a_td), .o_trn_tsof_n(a_tsof_n), .o_trn_teof_n(a_teof_n), .o_trn_tsrc_rdy_n(a_tsrc_n),
    .i_trn_tdst_rdy_n(dst_rdy_n), .o_trn_tsrc_dsc_n(a_dsc_n), .o_trn_tstr_n(a_tstr_n),
    .i_trn_tbuf_av(tbuf_av), .i_trn_lnk_up_n(lnk_up_n), .o_tx_busy(a_busy)
  );

  dlsc_pcie_s6_tx_arb #(.CPL_PRIO(1'b1), .BUF_AV_MIN(1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .o_ob_ready(p_ob_ready), .i_ob_valid(ob_valid), .i_ob_data(ob_data), .i_ob_last(ob_last),
    .o_cpl_ready(p_cpl_ready), .i_cpl_valid(cpl_valid), .i_cpl_data(cpl_data), .i_cpl_last(cpl_last),
    .o_trn_td(p_td), .o_trn_tsof_n(p_tsof_n), .o_trn_teof_n(p_teof_n), .o_trn_tsrc_rdy_n(p_tsrc_n),
    .i_trn_tdst_rdy_n(dst_rdy_n), .o_trn_tsrc_dsc_n(p_dsc_n), .o_trn_tstr_n(p_tstr_n),
    .i_trn_tbuf_av(tbuf_av), .i_trn_lnk_up_n(lnk_up_n), .o_tx_busy(p_busy)
  );

  typedef struct {
    int          cyc;
    logic        sof;
    logic        eof;
    logic [31:0] d;
  } out_t;

  logic [32:0] ob_q[$];
  logic [32:0] cpl_q[$];
  out_t        log_q[$];
  int          cyc, t0;
  int          n_checks = 0, n_pass = 0;
  bit          sel = 1'b0;

  logic        s_ob_rdy, s_cpl_rdy, s_tsrc_n, s_tsof_n, s_teof_n, s_busy, s_dsc_n, s_tstr_n;
  logic [31:0] s_td;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Sample the selected DUT's outputs
  task automatic sample();
    s_ob_rdy  = sel ? p_ob_ready  : a_ob_ready;
    s_cpl_rdy = sel ? p_cpl_ready : a_cpl_ready;
    s_tsrc_n  = sel ? p_tsrc_n    : a_tsrc_n;
    s_tsof_n  = sel ? p_tsof_n    : a_tsof_n;
    s_teof_n  = sel ? p_teof_n    : a_teof_n;
    s_busy    = sel ? p_busy      : a_busy;
    s_dsc_n   = sel ? p_dsc_n     : a_dsc_n;
    s_tstr_n  = sel ? p_tstr_n    : a_tstr_n;
    s_td      = sel ? p_td        : a_td;
  endtask

  // One clock cycle: drive at negedge, sample just before posedge, retire accepts
  task automatic step();
    logic ob_acc, cpl_acc;
    out_t e;
    ob_valid  = (ob_q.size() != 0);
    ob_data   = ob_valid ? ob_q[0][31:0] : 32'h0;
    ob_last   = ob_valid ? ob_q[0][32] : 1'b0;
    cpl_valid = (cpl_q.size() != 0);
    cpl_data  = cpl_valid ? cpl_q[0][31:0] : 32'h0;
    cpl_last  = cpl_valid ? cpl_q[0][32] : 1'b0;
    #4;
    sample();
    ob_acc  = ob_valid && s_ob_rdy;
    cpl_acc = cpl_valid && s_cpl_rdy;
    if (!s_tsrc_n && !dst_rdy_n) begin
      e.cyc = cyc; e.sof = !s_tsof_n; e.eof = !s_teof_n; e.d = s_td;
      log_q.push_back(e);
    end
    @(negedge clk);
    if (ob_acc)  ob_q.delete(0);
    if (cpl_acc) cpl_q.delete(0);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ob_q.delete(); cpl_q.delete();
    ob_valid = 1'b1; cpl_valid = 1'b1;
    #4;
    sample();
    check("rst tsrc_rdy_n", 64'(s_tsrc_n), 64'd1);
    check("rst sof/eof_n",  64'({s_tsof_n, s_teof_n}), 64'b11);
    check("rst td",         64'(s_td), 64'd0);
    check("rst readys",     64'({s_ob_rdy, s_cpl_rdy}), 64'b00);
    check("rst busy",       64'(s_busy), 64'd0);
    check("rst dsc/tstr_n", 64'({s_dsc_n, s_tstr_n}), 64'b11);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic begin_test();
    log_q.delete();
    t0 = cyc;
  endtask

  task automatic push_ob(input logic [31:0] d, input logic last);
    ob_q.push_back({last, d});
  endtask

  task automatic push_cpl(input logic [31:0] d, input logic last);
    cpl_q.push_back({last, d});
  endtask

  // Compare one logged output word: {relative cycle, sof, eof, data}
  task automatic chk_out(input string tag, input int idx, input logic [31:0] d,
                         input logic sof, input logic eof, input int rel);
    if (idx < log_q.size())
      check(tag, {16'(log_q[idx].cyc - t0), 7'b0, log_q[idx].sof, 7'b0, log_q[idx].eof, log_q[idx].d},
                 {16'(rel), 7'b0, sof, 7'b0, eof, d});
    else
      check({tag, " missing"}, 64'(log_q.size()), 64'(idx + 1));
  endtask

  initial begin
    int eofs;
    rst_n = 1'b0; dst_rdy_n = 1'b0; lnk_up_n = 1'b0; tbuf_av = 6'd8;
    ob_valid = 1'b0; cpl_valid = 1'b0; ob_data = '0; cpl_data = '0; ob_last = 1'b0; cpl_last = 1'b0;
    @(negedge clk);
    do_reset();

    // single 3-word OB packet
    begin_test();
    push_ob(32'hA0, 0); push_ob(32'hA1, 0); push_ob(32'hA2, 1);
    step();
    check("T1 first accept", 64'(s_ob_rdy), 64'd1);
    step();
    check("T1 busy", 64'(s_busy), 64'd1);
    run(4);
    check("T1 count", 64'(log_q.size()), 64'd3);
    chk_out("T1 w0", 0, 32'hA0, 1, 0, 1);
    chk_out("T1 w1", 1, 32'hA1, 0, 0, 2);
    chk_out("T1 w2", 2, 32'hA2, 0, 1, 3);

    // tie from reset: CPL wins, no gap between packets
    do_reset();
    begin_test();
    push_ob(32'h10, 0); push_ob(32'h11, 1);
    push_cpl(32'h20, 0); push_cpl(32'h21, 1);
    run(7);
    check("T2 count", 64'(log_q.size()), 64'd4);
    chk_out("T2 w0", 0, 32'h20, 1, 0, 1);
    chk_out("T2 w1", 1, 32'h21, 0, 1, 2);
    chk_out("T2 w2", 2, 32'h10, 1, 0, 3);
    chk_out("T2 w3", 3, 32'h11, 0, 1, 4);

    // single-word CPL, then a tie goes to OB
    begin_test();
    push_cpl(32'h30, 1);
    run(3);
    chk_out("T2b single", 0, 32'h30, 1, 1, 1);
    begin_test();
    push_ob(32'h40, 1); push_cpl(32'h50, 1);
    run(4);
    check("T2c count", 64'(log_q.size()), 64'd2);
    chk_out("T2c ob", 0, 32'h40, 1, 1, 1);
    chk_out("T2c cpl", 1, 32'h50, 1, 1, 2);

    // fixed CPL priority
    sel = 1'b1;
    do_reset();
    begin_test();
    push_cpl(32'h60, 0); push_cpl(32'h61, 1);
    push_cpl(32'h62, 0); push_cpl(32'h63, 1);
    push_cpl(32'h64, 0); push_cpl(32'h65, 1);
    push_ob(32'h70, 0);  push_ob(32'h71, 1);
    run(11);
    check("T3 count", 64'(log_q.size()), 64'd8);
    for (int i = 0; i < 6; i++)
      chk_out("T3 cpl", i, 32'h60 + 32'(i), (i % 2) == 0, (i % 2) == 1, i + 1);
    chk_out("T3 ob0", 6, 32'h70, 1, 0, 7);
    chk_out("T3 ob1", 7, 32'h71, 0, 1, 8);
    sel = 1'b0;

    // 4-cycle destination stall mid-packet
    do_reset();
    begin_test();
    push_ob(32'h80, 0); push_ob(32'h81, 0); push_ob(32'h82, 0); push_ob(32'h83, 1);
    for (int rel = 0; rel < 11; rel++) begin
      dst_rdy_n = (rel >= 2 && rel <= 5);
      step();
      if (rel >= 2 && rel <= 5) begin
        check("T4 stall td", 64'(s_td), 64'h81);
        check("T4 stall tsrc/sof/eof", 64'({s_tsrc_n, s_tsof_n, s_teof_n}), 64'b011);
      end
    end
    dst_rdy_n = 1'b0;
    check("T4 count", 64'(log_q.size()), 64'd4);
    chk_out("T4 w0", 0, 32'h80, 1, 0, 1);
    chk_out("T4 w1", 1, 32'h81, 0, 0, 6);
    chk_out("T4 w2", 2, 32'h82, 0, 0, 7);
    chk_out("T4 w3", 3, 32'h83, 0, 1, 8);
    eofs = 0;
    foreach (log_q[i]) if (log_q[i].eof) eofs++;
    check("T4 eof once", 64'(eofs), 64'd1);

    // no buffers, then buffers; mid-packet drop ignored
    begin_test();
    tbuf_av = 6'd0;
    push_ob(32'h90, 0); push_ob(32'h91, 1);
    for (int rel = 0; rel < 3; rel++) begin
      step();
      check("T5 no grant", 64'({s_ob_rdy, s_tsrc_n}), 64'b01);
    end
    tbuf_av = 6'd2;
    step();
    tbuf_av = 6'd0;
    run(4);
    check("T5 count", 64'(log_q.size()), 64'd2);
    chk_out("T5 w0", 0, 32'h90, 1, 0, 4);
    chk_out("T5 w1", 1, 32'h91, 0, 1, 5);
    begin_test();
    tbuf_av = 6'd1;
    push_ob(32'h95, 1);
    run(3);
    chk_out("T5 min buf", 0, 32'h95, 1, 1, 1);
    tbuf_av = 6'd8;

    // link drop on word 2 of a 4-word packet
    begin_test();
    push_ob(32'hB0, 0); push_ob(32'hB1, 0); push_ob(32'hB2, 0); push_ob(32'hB3, 1);
    push_ob(32'hC0, 0); push_ob(32'hC1, 1);
    step();
    lnk_up_n = 1'b1;
    step();
    check("T6 down readys/tsrc", 64'({s_ob_rdy, s_cpl_rdy, s_tsrc_n}), 64'b111);
    lnk_up_n = 1'b0;
    for (int rel = 2; rel < 4; rel++) begin
      step();
      check("T6 drain ready/tsrc", 64'({s_ob_rdy, s_tsrc_n}), 64'b11);
    end
    run(5);
    check("T6 consumed", 64'(ob_q.size()), 64'd0);
    check("T6 count", 64'(log_q.size()), 64'd2);
    chk_out("T6 c0", 0, 32'hC0, 1, 0, 5);
    chk_out("T6 c1", 1, 32'hC1, 0, 1, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
